sync_stream_fifo: RTL and testbench

Parametrised single-clock FIFO for buffering streaming sample paths, e.g. FFT magnitude bins feeding the HDMI overlay writer.
- Generalises the team's distributed-RAM FIFO wrapper with a selectable standard or first-word-fall-through (FWFT) read mode.
- Adds runtime-programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags.
- Storage is distributed RAM with a registered level counter.

---
 rtl/sync_fifo_pkg.sv | 19 +
 rtl/sync_fifo_dram.sv | 29 ++
 rtl/sync_stream_fifo.sv | 184 ++++++++++++++++++
 tb/tb_sync_stream_fifo.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous stream FIFO: legal parameter
// ranges, depth helper and the read-mode encoding.
package sync_fifo_pkg;

    localparam int ADDR_WIDTH_MIN = 4;
    localparam int ADDR_WIDTH_MAX = 10;
    localparam int DATA_WIDTH_MIN = 1;
    localparam int DATA_WIDTH_MAX = 256;

    typedef enum logic {
        MODE_STD  = 1'b0,
        MODE_FWFT = 1'b1
    } read_mode_e;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/sync_fifo_dram.sv
// DEPTH x DATA_WIDTH distributed RAM: synchronous write, asynchronous read.
module sync_fifo_dram
    import sync_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: contents are never reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_stream_fifo.sv
// Single-clock streaming FIFO with standard or FWFT read mode, programmable
// almost-full/almost-empty thresholds, flush and sticky error flags.
// Optional peak occupancy tracking: define SYNC_STREAM_FIFO_PEAK_LEVEL_EN.
module sync_stream_fifo
    import sync_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  almost_empty,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [ADDR_WIDTH:0]   water_level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err,
    output logic [ADDR_WIDTH:0]   peak_level
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         level_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    sync_fifo_dram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_dram (
        .clk    (clk),
        .wr_en  (wr_accept),
        .wr_addr(wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data(wr_data),
        .rd_addr(rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data(ram_rd_data)
    );

    // Accept decisions, next pointers/level and sticky error flags; flush
    // discards any transfer in the same cycle but never touches the errors.
    always_comb begin
        wr_accept   = wr_en && !full_q && !flush;
        rd_accept   = rd_en && !empty_q && !flush;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_accept) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (wr_accept && !rd_accept) begin
                level_d = level_q + PW'(1);
            end else if (rd_accept && !wr_accept) begin
                level_d = level_q - PW'(1);
            end
        end

        full_d  = (level_d == PW'(DEPTH));
        empty_d = (level_d == '0);

        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full_q) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty_q) begin
            underflow_d = 1'b1;
        end
    end

    // Pointer, level and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    generate
        if (FWFT == int'(MODE_FWFT)) begin : g_fwft
            assign rd_data = ram_rd_data;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

            // Output word loads only on an accepted read and holds otherwise.
            always_comb begin
                rd_data_d = rd_data_q;
                if (rd_accept) begin
                    rd_data_d = ram_rd_data;
                end
            end

            // Registered read data; flush deliberately leaves it alone.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q <= '0;
                end else begin
                    rd_data_q <= rd_data_d;
                end
            end

            assign rd_data = rd_data_q;
        end
    endgenerate

`ifdef SYNC_STREAM_FIFO_PEAK_LEVEL_EN
    logic [PW-1:0] peak_q, peak_d;

    // High-water mark: clearing beats tracking a new maximum.
    always_comb begin
        peak_d = peak_q;
        if (flush || clr_err) begin
            peak_d = '0;
        end else if (level_q > peak_q) begin
            peak_d = level_q;
        end
    end

    // Peak register.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_level = peak_q;
`else
    assign peak_level = '0;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign water_level  = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign almost_full  = (af_thresh != '0) && (level_q >= af_thresh);
    assign almost_empty = (level_q <= ae_thresh);

endmodule

// File: tb/tb_sync_stream_fifo.sv
// Directed testbench for sync_stream_fifo: one standard-mode and one FWFT
// instance share all inputs, so their occupancy evolves identically.
module tb_sync_stream_fifo;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW:0]   af_thresh = 5'd12;
    logic [AW:0]   ae_thresh = 5'd3;
    logic          clr_err = 1'b0;

    logic          full_s, afull_s, empty_s, aempty_s, ovf_s, unf_s;
    logic [DW-1:0] rd_data_s;
    logic [AW:0]   level_s, peak_s;

    logic          full_f, afull_f, empty_f, aempty_f, ovf_f, unf_f;
    logic [DW-1:0] rd_data_f;
    logic [AW:0]   level_f, peak_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_stream_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
        .full(full_s), .almost_full(afull_s), .rd_data(rd_data_s), .rd_en(rd_en),
        .empty(empty_s), .almost_empty(aempty_s), .af_thresh(af_thresh),
        .ae_thresh(ae_thresh), .water_level(level_s), .overflow(ovf_s),
        .underflow(unf_s), .clr_err(clr_err), .peak_level(peak_s)
    );

    sync_stream_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
        .full(full_f), .almost_full(afull_f), .rd_data(rd_data_f), .rd_en(rd_en),
        .empty(empty_f), .almost_empty(aempty_f), .af_thresh(af_thresh),
        .ae_thresh(ae_thresh), .water_level(level_f), .overflow(ovf_f),
        .underflow(unf_f), .clr_err(clr_err), .peak_level(peak_f)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_words(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            wr_data = base + DW'(i);
            wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (empty_s !== 1'b1 || full_s !== 1'b0 || level_s !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_flags: empty=%b full=%b level=%0d, required 1 0 0", empty_s, full_s, level_s);
        end
        checks++;
        if (ovf_s !== 1'b0 || unf_s !== 1'b0 || rd_data_s !== 16'h0 || peak_s !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_regs: ovf=%b unf=%b rd_data=%h peak=%0d, required 0 0 0000 0", ovf_s, unf_s, rd_data_s, peak_s);
        end
    endtask

    task automatic test_fill_drain();
        do_reset();
        write_words(15, 16'h0001);
        checks++;
        if (full_s !== 1'b0 || level_s !== 5'd15) begin
            errors++;
            $display("[TB] FAIL fill15: full=%b level=%0d, required 0 15", full_s, level_s);
        end
        write_words(1, 16'h0010);
        checks++;
        if (full_s !== 1'b1 || level_s !== 5'd16 || empty_s !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill16: full=%b level=%0d empty=%b, required 1 16 0", full_s, level_s, empty_s);
        end
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            checks++;
            if (rd_data_s !== DW'(i + 1)) begin
                errors++;
                $display("[TB] FAIL drain_data[%0d]: got %h, required %h", i, rd_data_s, DW'(i + 1));
            end
        end
        rd_en = 1'b0;
        checks++;
        if (empty_s !== 1'b1 || level_s !== 5'd0 || full_s !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_end: empty=%b level=%0d full=%b, required 1 0 0", empty_s, level_s, full_s);
        end
    endtask

    task automatic test_errors();
        do_reset();
        write_words(16, 16'h0020);
        wr_data = 16'hDEAD;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        checks++;
        if (ovf_s !== 1'b1 || level_s !== 5'd16 || unf_s !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow_set: ovf=%b level=%0d unf=%b, required 1 16 0", ovf_s, level_s, unf_s);
        end
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            checks++;
            if (rd_data_s !== 16'h0020 + DW'(i)) begin
                errors++;
                $display("[TB] FAIL ovf_drain[%0d]: got %h, required %h", i, rd_data_s, 16'h0020 + DW'(i));
            end
        end
        checks++;
        if (empty_s !== 1'b1 || unf_s !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_drain_end: empty=%b unf=%b, required 1 0", empty_s, unf_s);
        end
        tick();
        rd_en = 1'b0;
        checks++;
        if (unf_s !== 1'b1 || rd_data_s !== 16'h002F || level_s !== 5'd0) begin
            errors++;
            $display("[TB] FAIL underflow_set: unf=%b rd_data=%h level=%0d, required 1 002f 0", unf_s, rd_data_s, level_s);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if (ovf_s !== 1'b0 || unf_s !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_err: ovf=%b unf=%b, required 0 0", ovf_s, unf_s);
        end
        write_words(16, 16'h0040);
        wr_en = 1'b1;
        clr_err = 1'b1;
        tick();
        wr_en = 1'b0;
        clr_err = 1'b0;
        checks++;
        if (ovf_s !== 1'b1 || unf_s !== 1'b0) begin
            errors++;
            $display("[TB] FAIL set_beats_clr: ovf=%b unf=%b, required 1 0", ovf_s, unf_s);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        write_words(8, 16'h0100);
        for (int k = 0; k < 40; k++) begin
            wr_data = 16'h0108 + DW'(k);
            wr_en = 1'b1;
            rd_en = 1'b1;
            tick();
            checks++;
            if (rd_data_s !== 16'h0100 + DW'(k) || level_s !== 5'd8) begin
                errors++;
                $display("[TB] FAIL b2b[%0d]: rd_data=%h level=%0d, required %h 8", k, rd_data_s, level_s, 16'h0100 + DW'(k));
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_fwft();
        do_reset();
        checks++;
        if (empty_f !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fwft_reset_empty: got %b, required 1", empty_f);
        end
        write_words(1, 16'hABCD);
        checks++;
        if (empty_f !== 1'b0 || rd_data_f !== 16'hABCD) begin
            errors++;
            $display("[TB] FAIL fwft_first_word: empty=%b rd_data=%h, required 0 abcd", empty_f, rd_data_f);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (empty_f !== 1'b1 || rd_data_s !== 16'hABCD) begin
            errors++;
            $display("[TB] FAIL fwft_pop: empty=%b std_rd_data=%h, required 1 abcd", empty_f, rd_data_s);
        end
        write_words(1, 16'h1111);
        write_words(1, 16'h2222);
        checks++;
        if (rd_data_f !== 16'h1111 || level_f !== 5'd2) begin
            errors++;
            $display("[TB] FAIL fwft_head: rd_data=%h level=%0d, required 1111 2", rd_data_f, level_f);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_data_f !== 16'h2222 || empty_f !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fwft_next: rd_data=%h empty=%b, required 2222 0", rd_data_f, empty_f);
        end
    endtask

    task automatic test_thresholds();
        do_reset();
        af_thresh = 5'd12;
        ae_thresh = 5'd3;
        #1;
        checks++;
        if (aempty_s !== 1'b1 || afull_s !== 1'b0) begin
            errors++;
            $display("[TB] FAIL thr_level0: ae=%b af=%b, required 1 0", aempty_s, afull_s);
        end
        for (int lvl = 1; lvl <= 13; lvl++) begin
            write_words(1, DW'(lvl));
            checks++;
            if (afull_s !== (lvl >= 12) || aempty_s !== (lvl <= 3)) begin
                errors++;
                $display("[TB] FAIL thr_level%0d: af=%b ae=%b, required %b %b", lvl, afull_s, aempty_s, lvl >= 12, lvl <= 3);
            end
        end
        af_thresh = 5'd0;
        #1;
        checks++;
        if (afull_s !== 1'b0) begin
            errors++;
            $display("[TB] FAIL thr_af_zero: af=%b, required 0", afull_s);
        end
        af_thresh = 5'd17;
        write_words(3, 16'h0);
        checks++;
        if (afull_s !== 1'b0 || full_s !== 1'b1) begin
            errors++;
            $display("[TB] FAIL thr_af_above_depth: af=%b full=%b, required 0 1", afull_s, full_s);
        end
        af_thresh = 5'd16;
        #1;
        checks++;
        if (afull_s !== 1'b1) begin
            errors++;
            $display("[TB] FAIL thr_af_depth: af=%b, required 1", afull_s);
        end
        af_thresh = 5'd12;
    endtask

    task automatic test_flush();
        do_reset();
        write_words(16, 16'h0300);
        write_words(1, 16'hBEEF);
        for (int i = 0; i < 6; i++) begin
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        checks++;
        if (level_s !== 5'd10 || ovf_s !== 1'b1 || rd_data_s !== 16'h0305) begin
            errors++;
            $display("[TB] FAIL flush_setup: level=%0d ovf=%b rd_data=%h, required 10 1 0305", level_s, ovf_s, rd_data_s);
        end
        flush = 1'b1;
        wr_en = 1'b1;
        wr_data = 16'h5555;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        checks++;
        if (level_s !== 5'd0 || empty_s !== 1'b1 || ovf_s !== 1'b1 || rd_data_s !== 16'h0305) begin
            errors++;
            $display("[TB] FAIL flush: level=%0d empty=%b ovf=%b rd_data=%h, required 0 1 1 0305", level_s, empty_s, ovf_s, rd_data_s);
        end
        write_words(1, 16'h0077);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (rd_data_s !== 16'h0077 || empty_s !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_flush: rd_data=%h empty=%b, required 0077 1", rd_data_s, empty_s);
        end
    endtask

    task automatic test_peak();
        do_reset();
        write_words(5, 16'h0);
        tick();
        write_words(4, 16'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        tick();
`ifdef SYNC_STREAM_FIFO_PEAK_LEVEL_EN
        checks++;
        if (peak_s !== 5'd9 || level_s !== 5'd4) begin
            errors++;
            $display("[TB] FAIL peak_max: peak=%0d level=%0d, required 9 4", peak_s, level_s);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if (peak_s !== 5'd0) begin
            errors++;
            $display("[TB] FAIL peak_clear: peak=%0d, required 0", peak_s);
        end
        tick();
        checks++;
        if (peak_s !== 5'd4) begin
            errors++;
            $display("[TB] FAIL peak_retrack: peak=%0d, required 4", peak_s);
        end
        write_words(2, 16'h0);
        tick();
        checks++;
        if (peak_s !== 5'd6) begin
            errors++;
            $display("[TB] FAIL peak_new_max: peak=%0d, required 6", peak_s);
        end
`else
        checks++;
        if (peak_s !== 5'd0 || level_s !== 5'd4) begin
            errors++;
            $display("[TB] FAIL peak_disabled: peak=%0d level=%0d, required 0 4", peak_s, level_s);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_errors();
        test_back_to_back();
        test_fwft();
        test_thresholds();
        test_flush();
        test_peak();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
